// File: rtl/wb_sevenseg_pkg.sv
// Register map, CTRL field positions, reset constants and the hex segment
// table shared by the seven-segment display controller and its decoder.
package wb_sevenseg_pkg;

    typedef enum logic [1:0] {
        ADR_DATA   = 2'd0,
        ADR_CTRL   = 2'd1,
        ADR_PERIOD = 2'd2,
        ADR_STATUS = 2'd3
    } reg_adr_e;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_BLANK_LSB   = 8;
    localparam int CTRL_DP_LSB      = 16;
    localparam int CTRL_BRIGHT_LSB  = 24;
    localparam int STATUS_FRAME_LSB = 16;

    localparam logic [31:0] DATA_RESET = 32'h0000_0000;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

    // Active-low segment patterns, bit order gfedcba, indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (gfedcba).
module sevenseg_decode
    import wb_sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/wb_sevenseg_mux.sv
// Wishbone-slave scanner for a multiplexed common-anode hex display with
// run-time refresh period, per-digit blank/dp masks and PWM brightness.
module wb_sevenseg_mux
    import wb_sevenseg_pkg::*;
#(
    parameter int          NUM_DIGITS = 8,
    parameter logic [31:0] CNT_RESET  = 32'h0001_86A0,
    parameter int          PWM_BITS   = 4
) (
    input  logic                  i_wb_clk,
    input  logic                  i_wb_rst,
    input  logic [1:0]            i_wb_adr,
    input  logic [31:0]           i_wb_dat,
    input  logic [3:0]            i_wb_sel,
    input  logic                  i_wb_we,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    output logic [31:0]           o_wb_rdt,
    output logic                  o_wb_ack,
    output logic [6:0]            o_ca,
    output logic                  o_dp,
    output logic [NUM_DIGITS-1:0] o_an
);

    localparam logic [2:0]  LAST_IDX    = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]  DIGIT_MASK  = 8'((1 << NUM_DIGITS) - 1);
    localparam logic [31:0] BRIGHT_FULL = 32'((1 << PWM_BITS) - 1) << CTRL_BRIGHT_LSB;
    localparam logic [31:0] CTRL_MASK   = (32'd1 << CTRL_EN_BIT)
                                        | (32'(DIGIT_MASK) << CTRL_BLANK_LSB)
                                        | (32'(DIGIT_MASK) << CTRL_DP_LSB)
                                        | BRIGHT_FULL;
    localparam logic [31:0] CTRL_RESET  = (32'd1 << CTRL_EN_BIT) | BRIGHT_FULL;

    logic [31:0]           data_q, data_d;
    logic [31:0]           ctrl_q, ctrl_d;
    logic [31:0]           period_q, period_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [15:0]           frame_q, frame_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic                  ack_q, ack_d;
    logic [31:0]           rdt_q, rdt_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            ca_q, ca_d;
    logic                  dp_q, dp_d;

    reg_adr_e              adr;
    logic                  req;
    logic [31:0]           status_rd;
    logic [31:0]           rd_mux;
    logic                  en;
    logic [7:0]            blank;
    logic [7:0]            dpm;
    logic [PWM_BITS-1:0]   bright;
    logic                  lit;
    logic [3:0]            nibble;
    logic [6:0]            seg;
    logic [7:0]            an_onehot;

    assign adr = reg_adr_e'(i_wb_adr);
    // A strobe held across the ack cycle is not a new request.
    assign req = i_wb_cyc & i_wb_stb & ~ack_q;

    assign status_rd = {frame_q, 13'd0, idx_q};

    always_comb begin
        unique case (adr)
            ADR_DATA:   rd_mux = data_q;
            ADR_CTRL:   rd_mux = ctrl_q;
            ADR_PERIOD: rd_mux = period_q;
            ADR_STATUS: rd_mux = status_rd;
        endcase
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        period_d = period_q;
        if (req && i_wb_we) begin
            unique case (adr)
                ADR_DATA:   data_d   = byte_merge(data_q, i_wb_dat, i_wb_sel);
                ADR_CTRL:   ctrl_d   = byte_merge(ctrl_q, i_wb_dat, i_wb_sel) & CTRL_MASK;
                ADR_PERIOD: period_d = byte_merge(period_q, i_wb_dat, i_wb_sel);
                ADR_STATUS: ;
            endcase
        end
    end

    assign ack_d = req;
    assign rdt_d = req ? rd_mux : rdt_q;

    always_comb begin
        cnt_d   = cnt_q - 32'd1;
        idx_d   = idx_q;
        frame_d = frame_q;
        if (cnt_q == 32'd0) begin
            cnt_d = period_q;
            if (idx_q == LAST_IDX) begin
                idx_d   = 3'd0;
                frame_d = frame_q + 16'd1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    assign pwm_d = pwm_q + 1'b1;

    assign en     = ctrl_q[CTRL_EN_BIT];
    assign blank  = ctrl_q[CTRL_BLANK_LSB +: 8];
    assign dpm    = ctrl_q[CTRL_DP_LSB +: 8];
    assign bright = ctrl_q[CTRL_BRIGHT_LSB +: PWM_BITS];

    assign lit       = en & ~blank[idx_q] & ((&bright) | (pwm_q < bright));
    assign nibble    = data_q[{idx_q, 2'b00} +: 4];
    assign an_onehot = ~(8'd1 << idx_q);

    sevenseg_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (seg)
    );

    // Anode and cathodes come from one register stage so they switch together.
    always_comb begin
        an_d = '1;
        ca_d = SEG_OFF;
        dp_d = 1'b1;
        if (lit) begin
            an_d = an_onehot[NUM_DIGITS-1:0];
            ca_d = seg;
            dp_d = ~dpm[idx_q];
        end
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            data_q   <= DATA_RESET;
            ctrl_q   <= CTRL_RESET;
            period_q <= CNT_RESET;
            cnt_q    <= CNT_RESET;
            idx_q    <= 3'd0;
            frame_q  <= 16'd0;
            pwm_q    <= '0;
            ack_q    <= 1'b0;
            rdt_q    <= 32'd0;
            an_q     <= '1;
            ca_q     <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            pwm_q    <= pwm_d;
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            an_q     <= an_d;
            ca_q     <= ca_d;
            dp_q     <= dp_d;
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_an     = an_q;
    assign o_ca     = ca_q;
    assign o_dp     = dp_q;

endmodule
